// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator stage and its ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 3;

    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Command captured at the accept edge and held for the EXEC cycle.
    typedef struct packed {
        logic                load;
        alu_op_e             op;
        logic [DATA_W-1:0]   operand;
    } cmd_t;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: result plus carry, negative and zero flags.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              negative,
    output logic              zero
);

    logic [DATA_W:0] ext;

    // Carry on SUB is the inverted borrow out of bit 8.
    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ext[DATA_W];
            end
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ~ext[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
    end

    assign negative = result[DATA_W-1];
    assign zero     = (result == '0);

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator and flag registers around alu_8bit, with valid/ready command
// and response ports and a count of completed responses.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_load,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [DATA_W-1:0]   cmd_operand,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic [DATA_W-1:0]   acc,
    output logic [CNT_W-1:0]    op_count
);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_negative;
    logic                alu_zero;
    logic                cmd_fire;
    logic                rsp_fire;

    alu_8bit u_alu (
        .a        (acc_q),
        .b        (cmd_q.operand),
        .opcode   (cmd_q.op),
        .result   (alu_result),
        .carry    (alu_carry),
        .negative (alu_negative),
        .zero     (alu_zero)
    );

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // All state lives here; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; a load leaves the carry flag untouched.
    always_comb begin
        cmd_d   = cmd_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cmd_d.load    = cmd_load;
                    cmd_d.op      = alu_op_e'(cmd_op);
                    cmd_d.operand = cmd_operand;
                end
            end
            ST_EXEC: begin
                if (cmd_q.load) begin
                    acc_d           = cmd_q.operand;
                    flags_d[FLAG_N] = cmd_q.operand[DATA_W-1];
                    flags_d[FLAG_Z] = (cmd_q.operand == '0);
                end else begin
                    acc_d           = alu_result;
                    flags_d[FLAG_C] = alu_carry;
                    flags_d[FLAG_N] = alu_negative;
                    flags_d[FLAG_Z] = alu_zero;
                end
            end
            ST_RESP: begin
                if (rsp_fire) cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        if (state_q == ST_IDLE && !rst) cmd_ready = 1'b1;
        if (state_q == ST_RESP)         rsp_valid = 1'b1;
    end

    assign rsp_result = acc_q;
    assign rsp_flags  = flags_q;
    assign acc        = acc_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed testbench for alu_accumulator with hand-computed expected values.
module tb_alu_accumulator;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [7:0] acc;
    logic [7:0] op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt;

    alu_accumulator #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .acc         (acc),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command, wait for its response, then acknowledge it.
    task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [7:0] opnd,
                           output logic [7:0] res, output logic [2:0] flg,
                           output int lat, output bit ok);
        int w;
        ok  = 1'b0;
        res = '0;
        flg = '0;
        lat = 0;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) return;
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_op      = op;
        cmd_operand = opnd;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_load    = 1'b0;
        cmd_op      = 3'b000;
        cmd_operand = 8'hA5;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) return;
        res = rsp_result;
        flg = rsp_flags;
        ok  = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_low cyc%0d: got %b want 0", i, cmd_ready);
            end
        end
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
        end
        n_cmp++;
        if (acc !== 8'h00 || rsp_flags !== 3'b000 || rsp_valid !== 1'b0 || op_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: acc=%h flags=%b rsp_valid=%b op_count=%0d want 00/000/0/0",
                     acc, rsp_flags, rsp_valid, op_count);
        end
    endtask

    task automatic test_load_add();
        logic [7:0] r; logic [2:0] f; int l; bit ok;
        run_cmd(1'b1, OP_ADD, 8'h80, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h80 || f !== 3'b010 || l !== 2) begin
            n_fail++;
            $display("FAIL load_80: ok=%0d res=%h flags=%b lat=%0d want 80/010/2", ok, r, f, l);
        end
        run_cmd(1'b0, OP_ADD, 8'h80, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h00 || f !== 3'b101 || l !== 2) begin
            n_fail++;
            $display("FAIL add_80: ok=%0d res=%h flags=%b lat=%0d want 00/101/2", ok, r, f, l);
        end
        n_cmp++;
        if (op_count !== exp_cnt || acc !== 8'h00) begin
            n_fail++;
            $display("FAIL load_add_count: op_count=%0d acc=%h want %0d/00", op_count, acc, exp_cnt);
        end
    endtask

    task automatic test_sub_chain();
        logic [7:0] r; logic [2:0] f; int l; bit ok;
        run_cmd(1'b1, OP_ADD, 8'h05, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h05 || f !== 3'b100) begin
            n_fail++;
            $display("FAIL load_05: ok=%0d res=%h flags=%b want 05/100", ok, r, f);
        end
        run_cmd(1'b0, OP_SUB, 8'h07, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'hFE || f !== 3'b010) begin
            n_fail++;
            $display("FAIL sub_07: ok=%0d res=%h flags=%b want FE/010", ok, r, f);
        end
        run_cmd(1'b0, OP_SUB, 8'h01, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'hFD || f !== 3'b110) begin
            n_fail++;
            $display("FAIL sub_01: ok=%0d res=%h flags=%b want FD/110", ok, r, f);
        end
    endtask

    task automatic test_shifts();
        logic [7:0] r; logic [2:0] f; int l; bit ok;
        run_cmd(1'b1, OP_ADD, 8'h01, r, f, l, ok);
        run_cmd(1'b0, OP_SHR, 8'hFF, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h00 || f !== 3'b101) begin
            n_fail++;
            $display("FAIL shr_01: ok=%0d res=%h flags=%b want 00/101", ok, r, f);
        end
        run_cmd(1'b1, OP_ADD, 8'h81, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h81 || f !== 3'b110) begin
            n_fail++;
            $display("FAIL load_81: ok=%0d res=%h flags=%b want 81/110", ok, r, f);
        end
        run_cmd(1'b0, OP_SHL, 8'h00, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h02 || f !== 3'b100) begin
            n_fail++;
            $display("FAIL shl_81: ok=%0d res=%h flags=%b want 02/100", ok, r, f);
        end
    endtask

    task automatic test_logic();
        logic [7:0] r; logic [2:0] f; int l; bit ok;
        run_cmd(1'b1, OP_ADD, 8'hF0, r, f, l, ok);
        run_cmd(1'b0, OP_AND, 8'h3C, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h30 || f !== 3'b000) begin
            n_fail++;
            $display("FAIL and_3c: ok=%0d res=%h flags=%b want 30/000", ok, r, f);
        end
        run_cmd(1'b0, OP_OR, 8'h0F, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h3F || f !== 3'b000) begin
            n_fail++;
            $display("FAIL or_0f: ok=%0d res=%h flags=%b want 3F/000", ok, r, f);
        end
        run_cmd(1'b0, OP_XOR, 8'hFF, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'hC0 || f !== 3'b010) begin
            n_fail++;
            $display("FAIL xor_ff: ok=%0d res=%h flags=%b want C0/010", ok, r, f);
        end
        run_cmd(1'b0, OP_NOT, 8'h55, r, f, l, ok);
        n_cmp++;
        if (!ok || r !== 8'h3F || f !== 3'b000) begin
            n_fail++;
            $display("FAIL not: ok=%0d res=%h flags=%b want 3F/000", ok, r, f);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [7:0] cnt_before;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_load    = 1'b1;
        cmd_op      = OP_ADD;
        cmd_operand = 8'h33;
        @(posedge clk);
        #1;
        cmd_load    = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 20);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b want 1", rsp_valid);
        end
        cnt_before = op_count;
        for (int i = 0; i < 5; i++) begin
            cmd_operand = 8'h10 + 8'(i);
            cmd_op      = 3'(i);
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h33 || rsp_flags !== 3'b000 ||
                cmd_ready !== 1'b0 || op_count !== cnt_before || acc !== 8'h33) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: v=%b res=%h flags=%b rdy=%b cnt=%0d acc=%h want 1/33/000/0/%0d/33",
                         i, rsp_valid, rsp_result, rsp_flags, cmd_ready, op_count, acc, cnt_before);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        n_cmp++;
        if (op_count !== exp_cnt || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== 8'h33) begin
            n_fail++;
            $display("FAIL bp_release: cnt=%0d v=%b rdy=%b acc=%h want %0d/0/1/33",
                     op_count, rsp_valid, cmd_ready, acc, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_load    = 1'b0;
        cmd_op      = OP_ADD;
        cmd_operand = 8'h10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || acc !== 8'h00 || op_count !== 8'h00 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec: v=%b acc=%h cnt=%0d rdy=%b want 0/00/0/0",
                     rsp_valid, acc, op_count, cmd_ready);
        end
        rst = 1'b0;
        exp_cnt = '0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || acc !== 8'h00 || rsp_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_exec_after: rsp_seen=%b acc=%h flags=%b want 0/00/000", seen, acc, rsp_flags);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int accepts;
        int rsps;
        accepts = 0;
        rsps    = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_load    = 1'b0;
        cmd_op      = OP_XOR;
        cmd_operand = 8'h00;
        rsp_ready   = 1'b1;
        for (int i = 0; i < 768; i++) begin
            if (cmd_ready) accepts++;
            if (rsp_valid) rsps++;
            if (i == 765) begin
                n_cmp++;
                if (op_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: op_count=%0d want 255", op_count);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (accepts != 256 || rsps != 256) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts=%0d rsps=%0d want 256/256", accepts, rsps);
        end
        n_cmp++;
        if (op_count !== 8'h00 || acc !== 8'h00 || rsp_flags !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%0d acc=%h flags=%b want 0/00/001", op_count, acc, rsp_flags);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_load    = 1'b0;
        cmd_op      = 3'b000;
        cmd_operand = 8'h00;
        rsp_ready   = 1'b0;
        exp_cnt     = '0;
        test_reset();
        test_load_add();
        test_sub_chain();
        test_shifts();
        test_logic();
        test_backpressure();
        test_reset_mid_exec();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Accumulator-and-flags stage wrapped around the existing `alu_8bit` combinational ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU with the accumulator as operand A. On the capture edge it writes the ALU result and flags back into the accumulator and flag registers. It then presents the registered result on a valid/ready response port. It is the sequential consumer of the ALU's result, carry, negative and zero outputs, and the first stateful datapath block above it.

## Interface
- `CNT_W`, default 8, width of the completed-operation counter.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_load`  in  1  1 = load `cmd_operand` into ACC; 0 = ALU op.
- `cmd_op`  in  3  ALU opcode: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHL=110, SHR=111.
- `cmd_operand`  in  8  ALU operand B, or load value.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  8  new ACC value.
- `rsp_flags`  out  3  {C, N, Z} after the command.
- `acc`  out  8  current accumulator.
- `op_count`  out  `CNT_W`  completed responses, wraps modulo 2^`CNT_W`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` && `cmd_ready`, register `cmd_load`, `cmd_op` and `cmd_operand`, then go to EXEC.
- EXEC:
  - ALU inputs are a=ACC, b=registered operand, opcode=registered op.
  - At the end of the cycle, capture into ACC and flags, then go to RESP.
  - ALU op: ACC←result, C←ALU carry, N←ALU negative, Z←ALU zero.
  - Load: ACC←operand, N←operand[7], Z←(operand==0); C is unchanged.
- RESP:
  - `rsp_valid`=1; `rsp_result`=ACC; `rsp_flags`={C,N,Z}.
  - On `rsp_ready`: increment `op_count`, go to IDLE.
- Carry semantics are fixed by `alu_8bit`:
  - ADD: bit 8 of the sum.
  - SUB: NOT borrow (0x05−0x07 gives C=0).
  - SHL: a[7]. SHR: a[0].
  - Logic ops and NOT: 0.
- NOT, SHL and SHR ignore B; the operand is still consumed.
- All arithmetic is 8-bit and wraps modulo 256.
- `cmd_valid` is ignored in EXEC and RESP.
- `cmd_*` fields need only be stable in the accept cycle.

## Timing
- Reset values (`rst` high at a clock edge):
  - State=IDLE.
  - ACC=0x00, C=N=Z=0.
  - `rsp_valid`=0.
  - `op_count`=0.
  - Internal operand/op registers = 0.
- `cmd_ready`:
  - Combinational: (state==IDLE) && !`rst`.
  - 0 while `rst` is high; 1 in the first cycle after release.
- Latency:
  - Command accepted at edge k.
  - EXEC during cycle k..k+1.
  - ACC/flags update at edge k+1.
  - `rsp_valid` is high from edge k+1.
- Minimum spacing between accepts: 3 cycles when `rsp_ready` is tied high.
- Backpressure: while `rsp_ready`=0 in RESP:
  - `rsp_valid`, `rsp_result` and `rsp_flags` are held stable.
  - `cmd_ready` stays 0.
- `acc` and the flags change only at the EXEC capture edge or reset.
- Reset mid-operation (EXEC or RESP): the command is abandoned; no response is issued and `op_count` is not incremented.
- `op_count` wraps from 2^`CNT_W`−1 to 0 without any flag.

## Structure
- Package `alu_pkg`:
  - Opcode enum (the 8 codes above).
  - FSM state enum {IDLE, EXEC, RESP}.
  - Flag index constants FLAG_C=2, FLAG_N=1, FLAG_Z=0.
- One sub-module: `alu_8bit`, instantiated unchanged.
  - Ports: a, b, opcode → result, carry, negative, zero.
  - Inputs are driven from registers only, so the ALU path is register-to-register.
- Sequential logic: FSM, ACC, flags, operand/op registers, counter, all in one clocked block with synchronous reset.

## Test plan
- Reset:
  - Stimulus: hold `rst` 3 cycles, then release.
  - Response: `acc`=0x00, `rsp_flags`=000, `rsp_valid`=0, `op_count`=0; `cmd_ready`=0 during reset and 1 in the first cycle after.
- Load then ADD:
  - Stimulus: LOAD 0x80, then ADD 0x80.
  - Response: first `rsp_result`=0x80 with flags C=0 (unchanged), N=1, Z=0; second `rsp_result`=0x00 with C=1, N=0, Z=1.
- SUB chain:
  - Stimulus: LOAD 0x05, SUB 0x07, then SUB 0x01.
  - Response: 0xFE with C=0, N=1, then 0xFD with C=1, N=1.
- Shifts:
  - Stimulus: LOAD 0x01, SHR, then LOAD 0x81, SHL.
  - Response: 0x00 with C=1, Z=1, then 0x02 with C=1, N=0.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 and different operands.
  - Response: `rsp_result` and `rsp_flags` are stable; `cmd_ready`=0; no extra command is accepted; `op_count` increments by exactly 1 when ready rises.
- Reset mid-EXEC and counter wrap:
  - Stimulus: assert `rst` in the EXEC cycle of ADD 0x10.
  - Response: no `rsp_valid`; `acc`=0x00.
  - Then run 256 back-to-back XOR 0x00 commands.
  - Response: `op_count` returns to 0 (with `CNT_W`=8).
